// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the RV32I multicycle control path.
// Holds opcode constants, FSM state encoding, ALU operation codes, datapath
// mux select encodings and the branch-condition helper.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_EX_R   = 4'd2,  S_EX_I  = 4'd3,
    S_EX_ADDR = 4'd4,  S_EX_U   = 4'd5,  S_EX_J   = 4'd6,  S_EX_JR = 4'd7,
    S_EX_B    = 4'd8,  S_MEM_RD = 4'd9,  S_MEM_WR = 4'd10, S_WB_ALU = 4'd11,
    S_WB_MEM  = 4'd12, S_HALT   = 4'd13, S_FAULT  = 4'd14
  } state_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_XOR  = 4'b0011,
    ALU_SLL = 4'b0100, ALU_SRL = 4'b0101, ALU_SUB = 4'b0110, ALU_SLT  = 4'b0111,
    ALU_SRA = 4'b1000, ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;

  localparam logic [1:0] PC_ALU       = 2'b00;
  localparam logic [1:0] PC_ALUOUT    = 2'b01;
  localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

  // Branch condition from funct3 and the SUB flags; reserved funct3 never branches.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory request/ready handshake.
//   mem_req   - controller requests an access this cycle
//   mem_we    - access is a write
//   mem_ready - memory completes the access this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: combinational ALU operation select.
//   r_mode      - 1: register-register form, 0: immediate form
//   funct7      - IR[31:25]
//   funct3      - IR[14:12]
//   alu_control - ALU operation code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic       r_mode,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    if (r_mode) begin
      // Only the exact base-ISA encodings are honoured; anything else is ADD.
      case ({funct7, funct3})
        {7'h00, 3'b000}: alu_control = ALU_ADD;
        {7'h20, 3'b000}: alu_control = ALU_SUB;
        {7'h00, 3'b001}: alu_control = ALU_SLL;
        {7'h00, 3'b010}: alu_control = ALU_SLT;
        {7'h00, 3'b011}: alu_control = ALU_SLTU;
        {7'h00, 3'b100}: alu_control = ALU_XOR;
        {7'h00, 3'b101}: alu_control = ALU_SRL;
        {7'h20, 3'b101}: alu_control = ALU_SRA;
        {7'h00, 3'b110}: alu_control = ALU_OR;
        {7'h00, 3'b111}: alu_control = ALU_AND;
        default:         alu_control = ALU_ADD;
      endcase
    end else begin
      case (funct3)
        3'b000:  alu_control = ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b011:  alu_control = ALU_SLTU;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM for a shared-ALU datapath.
//   clk, resetn            - clock, synchronous active-low reset
//   opcode/funct3/funct7   - instruction fields from IR
//   alu_zero/lt/ltu        - flags of the SUB computed this cycle
//   mem                    - memory handshake (req/we out, ready in)
//   state                  - current FSM state
//   ir/pc/reg_write        - register enables
//   alu_src_a/b, alu_control, imm_src, result_src, pc_src - datapath selects
//   halted/fault           - in HALT / FAULT
//   instret                - retired-instruction count (wraps)
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 0,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               alu_zero,
  input  logic               alu_lt,
  input  logic               alu_ltu,
  multicycle_ctrl_if.master  mem,
  output logic [3:0]         state,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_control,
  output logic [2:0]         imm_src,
  output logic [1:0]         result_src,
  output logic [1:0]         pc_src,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   instret
);

  localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt;
  logic            rdy, mem_state, to_hit, go;
  logic            req, we;
  logic [3:0]      dec_ctl;

  assign rdy       = (MEM_HANDSHAKE != 0) ? mem.mem_ready : 1'b1;
  assign mem_state = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // Timeout wins over ready: the access is abandoned even if it completes now.
  assign to_hit    = (TIMEOUT > 0) && mem_state && (wait_cnt == WC_W'(TIMEOUT));
  assign go        = rdy && !to_hit;

  assign state       = state_q;
  assign mem.mem_req = req;
  assign mem.mem_we  = we;

  alu_decoder u_dec (
    .r_mode     (state_q == S_EX_R),
    .funct7     (funct7),
    .funct3     (funct3),
    .alu_control(dec_ctl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (go) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_EX_ADDR;
          OP_REG:            state_d = S_EX_R;
          OP_IMM:            state_d = S_EX_I;
          OP_LUI, OP_AUIPC:  state_d = S_EX_U;
          OP_JAL:            state_d = S_EX_J;
          OP_JALR:           state_d = S_EX_JR;
          OP_BRANCH:         state_d = S_EX_B;
          OP_FENCE:          state_d = S_FETCH;
          OP_SYSTEM:         state_d = S_HALT;
          default:           state_d = S_FAULT;
        endcase
      end
      S_EX_R, S_EX_I, S_EX_U:            state_d = S_WB_ALU;
      S_EX_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_EX_J, S_EX_JR, S_EX_B:           state_d = S_FETCH;
      S_MEM_RD: if (go) state_d = S_WB_MEM;
      S_MEM_WR: if (go) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM:                state_d = S_FETCH;
      S_HALT:                            state_d = S_HALT;
      default:                           state_d = S_FAULT;
    endcase
    if (to_hit) state_d = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)    wait_cnt <= '0;
      else if (mem_state && !rdy) wait_cnt <= wait_cnt + WC_W'(1);
      if (state_q != S_FETCH && state_d == S_FETCH) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    req         = 1'b0;
    we          = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    alu_control = ALU_AND;
    imm_src     = IMM_I;
    result_src  = RES_ALUOUT;
    pc_src      = PC_ALU;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1; alu_src_b = SRC_B_FOUR; alu_control = ALU_ADD;
        ir_write = go; pc_write = go;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC; alu_src_b = SRC_B_IMM; imm_src = IMM_B;
        alu_control = ALU_ADD;
      end
      S_EX_R: begin
        alu_src_a = SRC_A_REG; alu_control = dec_ctl;
      end
      S_EX_I: begin
        alu_src_a = SRC_A_REG; alu_src_b = SRC_B_IMM; alu_control = dec_ctl;
      end
      S_EX_ADDR: begin
        alu_src_a = SRC_A_REG; alu_src_b = SRC_B_IMM; alu_control = ALU_ADD;
        imm_src = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_EX_U: begin
        alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM; imm_src = IMM_U; alu_control = ALU_ADD;
      end
      S_EX_J: begin
        alu_src_a = SRC_A_OLDPC; alu_src_b = SRC_B_IMM; imm_src = IMM_J;
        alu_control = ALU_ADD; pc_write = 1'b1; reg_write = 1'b1; result_src = RES_PC;
      end
      S_EX_JR: begin
        alu_src_a = SRC_A_REG; alu_src_b = SRC_B_IMM; alu_control = ALU_ADD;
        pc_src = PC_ALU_ALIGN; pc_write = 1'b1; reg_write = 1'b1; result_src = RES_PC;
      end
      S_EX_B: begin
        alu_src_a = SRC_A_REG; alu_control = ALU_SUB;
        if (branch_taken(funct3, alu_zero, alu_lt, alu_ltu)) begin
          pc_write = 1'b1; pc_src = PC_ALUOUT;
        end
      end
      S_MEM_RD: req = 1'b1;
      S_MEM_WR: begin req = 1'b1; we = 1'b1; end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin reg_write = 1'b1; result_src = RES_MDR; end
      S_HALT:   halted = 1'b1;
      S_FAULT:  fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of per-state outputs on a
// no-handshake instance, plus hand-written multi-cycle sequences on a
// handshake instance with TIMEOUT=4 and a 2-bit instret.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, irw, pcw, rw;
    logic [1:0] sa, sb;
    logic [3:0] ac;
    logic [2:0] im;
    logic [1:0] rs, ps;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] fl;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic [6:0] op = '0, f7 = '0;
  logic [2:0] f3 = '0;
  logic zf = 1'b0, ltf = 1'b0, ltuf = 1'b0;

  multicycle_ctrl_if ifz ();
  multicycle_ctrl_if ifh ();

  logic [3:0]  st_z, ac_z, st_h, ac_h;
  logic        irw_z, pcw_z, rw_z, hlt_z, flt_z, irw_h, pcw_h, rw_h, hlt_h, flt_h;
  logic [1:0]  sa_z, sb_z, rs_z, ps_z, sa_h, sb_h, rs_h, ps_h;
  logic [2:0]  im_z, im_h;
  logic [31:0] cnt_z;
  logic [1:0]  cnt_h;

  multicycle_ctrl #(.MEM_HANDSHAKE(0), .TIMEOUT(0), .CNT_W(32)) u_z (
    .clk(clk), .resetn(resetn), .opcode(op), .funct3(f3), .funct7(f7),
    .alu_zero(zf), .alu_lt(ltf), .alu_ltu(ltuf), .mem(ifz), .state(st_z),
    .ir_write(irw_z), .pc_write(pcw_z), .reg_write(rw_z), .alu_src_a(sa_z),
    .alu_src_b(sb_z), .alu_control(ac_z), .imm_src(im_z), .result_src(rs_z),
    .pc_src(ps_z), .halted(hlt_z), .fault(flt_z), .instret(cnt_z));

  multicycle_ctrl #(.MEM_HANDSHAKE(1), .TIMEOUT(4), .CNT_W(2)) u_h (
    .clk(clk), .resetn(resetn), .opcode(op), .funct3(f3), .funct7(f7),
    .alu_zero(zf), .alu_lt(ltf), .alu_ltu(ltuf), .mem(ifh), .state(st_h),
    .ir_write(irw_h), .pc_write(pcw_h), .reg_write(rw_h), .alu_src_a(sa_h),
    .alu_src_b(sb_h), .alu_control(ac_h), .imm_src(im_h), .result_src(rs_h),
    .pc_src(ps_h), .halted(hlt_h), .fault(flt_h), .instret(cnt_h));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_instr = 0;
  vec_t tv[$];
  logic [6:0] c_op; logic [2:0] c_f3; logic [6:0] c_f7; logic [2:0] c_fl;
  logic [1:0] wb_rs, b_ps;
  logic       b_pcw;
  exp_t FE, DE, WBA, WBM, act;

  function automatic exp_t ex(input logic [3:0] st, input logic [4:0] f,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [3:0] ac, input logic [2:0] im,
                              input logic [1:0] rs, input logic [1:0] ps);
    return exp_t'({st, f, sa, sb, ac, im, rs, ps});
  endfunction

  task automatic row(input exp_t e);
    vec_t v;
    v.op = c_op; v.f3 = c_f3; v.f7 = c_f7; v.fl = c_fl; v.e = e;
    tv.push_back(v);
  endtask

  // Starts a new instruction: FETCH and DECODE rows are common to all.
  task automatic ins(input logic [6:0] o, input logic [2:0] fn3,
                     input logic [6:0] fn7, input logic [2:0] fl);
    c_op = o; c_f3 = fn3; c_f7 = fn7; c_fl = fl; n_instr++;
    row(FE); row(DE);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rst();
    resetn = 1'b0; step(); step(); resetn = 1'b1;
  endtask

  // Runs one instruction on the handshake instance until it returns to
  // FETCH (bounded), holding ready low for 'waits' cycles in memory states.
  task automatic run_h(input logic [6:0] o, input logic [2:0] fn3,
                       input logic [2:0] fl, input int waits,
                       output int cyc, output int nreq);
    int nw;
    op = o; f3 = fn3; f7 = '0; {zf, ltf, ltuf} = fl;
    cyc = 0; nreq = 0; nw = 0;
    for (int k = 0; k < 30; k++) begin
      ifh.mem_ready = !((st_h == 4'd9 || st_h == 4'd10) && nw < waits);
      #1;
      if (st_h == 4'd9 || st_h == 4'd10) begin
        if (ifh.mem_req) nreq++;
        if (!ifh.mem_ready) nw++;
      end
      if (st_h == 4'd12) wb_rs = rs_h;
      if (st_h == 4'd8) begin b_pcw = pcw_h; b_ps = ps_h; end
      step(); cyc++;
      if (st_h == 4'd0) break;
    end
  endtask

  initial begin
    int cyc, nreq;
    ifz.mem_ready = 1'b0;  // ignored by the no-handshake instance
    ifh.mem_ready = 1'b1;
    FE  = ex(4'd0,  5'b10110, 2'b00, 2'b10, 4'b0010, 3'b000, 2'b00, 2'b00);
    DE  = ex(4'd1,  5'b00000, 2'b01, 2'b01, 4'b0010, 3'b011, 2'b00, 2'b00);
    WBA = ex(4'd11, 5'b00001, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00);
    WBM = ex(4'd12, 5'b00001, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b01, 2'b00);

    // ---- vector table for the no-handshake instance ----
    ins(7'b0110011, 3'b000, 7'h00, 3'b000); // ADD
    row(ex(4'd2, 5'b0, 2'b10, 2'b00, 4'b0010, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0110011, 3'b000, 7'h20, 3'b000); // SUB
    row(ex(4'd2, 5'b0, 2'b10, 2'b00, 4'b0110, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0110011, 3'b011, 7'h00, 3'b000); // SLTU
    row(ex(4'd2, 5'b0, 2'b10, 2'b00, 4'b1001, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0110011, 3'b000, 7'h01, 3'b000); // undefined R combo -> ADD
    row(ex(4'd2, 5'b0, 2'b10, 2'b00, 4'b0010, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0110011, 3'b101, 7'h20, 3'b000); // SRA
    row(ex(4'd2, 5'b0, 2'b10, 2'b00, 4'b1000, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0010011, 3'b101, 7'h20, 3'b000); // SRAI
    row(ex(4'd3, 5'b0, 2'b10, 2'b01, 4'b1000, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0010011, 3'b101, 7'h00, 3'b000); // SRLI
    row(ex(4'd3, 5'b0, 2'b10, 2'b01, 4'b0101, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0010011, 3'b110, 7'h20, 3'b000); // ORI, funct7 ignored
    row(ex(4'd3, 5'b0, 2'b10, 2'b01, 4'b0001, 3'b000, 2'b00, 2'b00)); row(WBA);
    ins(7'b0110111, 3'b000, 7'h00, 3'b000); // LUI
    row(ex(4'd5, 5'b0, 2'b11, 2'b01, 4'b0010, 3'b100, 2'b00, 2'b00)); row(WBA);
    ins(7'b0010111, 3'b000, 7'h00, 3'b000); // AUIPC
    row(ex(4'd5, 5'b0, 2'b01, 2'b01, 4'b0010, 3'b100, 2'b00, 2'b00)); row(WBA);
    ins(7'b1101111, 3'b000, 7'h00, 3'b000); // JAL
    row(ex(4'd6, 5'b00011, 2'b01, 2'b01, 4'b0010, 3'b010, 2'b10, 2'b00));
    ins(7'b1100111, 3'b000, 7'h00, 3'b000); // JALR
    row(ex(4'd7, 5'b00011, 2'b10, 2'b01, 4'b0010, 3'b000, 2'b10, 2'b10));
    ins(7'b1100011, 3'b000, 7'h00, 3'b100); // BEQ taken
    row(ex(4'd8, 5'b00010, 2'b10, 2'b00, 4'b0110, 3'b000, 2'b00, 2'b01));
    ins(7'b1100011, 3'b000, 7'h00, 3'b000); // BEQ not taken
    row(ex(4'd8, 5'b00000, 2'b10, 2'b00, 4'b0110, 3'b000, 2'b00, 2'b00));
    ins(7'b1100011, 3'b100, 7'h00, 3'b010); // BLT taken
    row(ex(4'd8, 5'b00010, 2'b10, 2'b00, 4'b0110, 3'b000, 2'b00, 2'b01));
    ins(7'b1100011, 3'b111, 7'h00, 3'b001); // BGEU not taken
    row(ex(4'd8, 5'b00000, 2'b10, 2'b00, 4'b0110, 3'b000, 2'b00, 2'b00));
    ins(7'b1100011, 3'b001, 7'h00, 3'b000); // BNE taken
    row(ex(4'd8, 5'b00010, 2'b10, 2'b00, 4'b0110, 3'b000, 2'b00, 2'b01));
    ins(7'b0100011, 3'b010, 7'h00, 3'b000); // SW
    row(ex(4'd4, 5'b0, 2'b10, 2'b01, 4'b0010, 3'b001, 2'b00, 2'b00));
    row(ex(4'd10, 5'b11000, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00));
    ins(7'b0000011, 3'b010, 7'h00, 3'b000); // LW
    row(ex(4'd4, 5'b0, 2'b10, 2'b01, 4'b0010, 3'b000, 2'b00, 2'b00));
    row(ex(4'd9, 5'b10000, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00)); row(WBM);
    ins(7'b0001111, 3'b000, 7'h00, 3'b000); // FENCE retires from DECODE

    rst();
    #1;
    chk("z_rst_state", st_z, 0);
    chk("z_rst_req", ifz.mem_req, 1);
    chk("z_rst_instret", cnt_z, 0);
    for (int i = 0; i < tv.size(); i++) begin
      op = tv[i].op; f3 = tv[i].f3; f7 = tv[i].f7; {zf, ltf, ltuf} = tv[i].fl;
      #1;
      act = {st_z, ifz.mem_req, ifz.mem_we, irw_z, pcw_z, rw_z,
             sa_z, sb_z, ac_z, im_z, rs_z, ps_z};
      checks++;
      if (act !== tv[i].e) begin
        errors++;
        $display("FAIL tbl[%0d] got %h expected %h", i, act, tv[i].e);
      end
      step();
    end
    #1;
    chk("z_end_state", st_z, 0);
    chk("z_instret", cnt_z, n_instr);

    // ---- handshake instance: reset and FETCH wait gating ----
    ifh.mem_ready = 1'b1;
    rst();
    #1;
    chk("h_rst_state", st_h, 0);
    chk("h_rst_req", ifh.mem_req, 1);
    chk("h_rst_instret", cnt_h, 0);
    chk("h_rst_flags", {hlt_h, flt_h}, 0);
    op = 7'b0001111; ifh.mem_ready = 1'b0; #1;
    chk("fetch_wait_irw", irw_h, 0);
    chk("fetch_wait_pcw", pcw_h, 0);
    step();
    chk("fetch_wait_state", st_h, 0);
    ifh.mem_ready = 1'b1; #1;
    chk("fetch_rdy_irw", irw_h, 1);
    step(); step();
    chk("fence_instret", cnt_h, 1);

    // ---- LW with 3 wait cycles in MEM_RD ----
    run_h(7'b0000011, 3'b010, 3'b000, 3, cyc, nreq);
    chk("lw_cycles", cyc, 8);
    chk("lw_req_cycles", nreq, 4);
    chk("lw_wb_result", wb_rs, 2'b01);
    chk("lw_instret", cnt_h, 2);

    // ---- BEQ taken / not taken ----
    run_h(7'b1100011, 3'b000, 3'b100, 0, cyc, nreq);
    chk("beq_t_cycles", cyc, 3);
    chk("beq_t_pcw", b_pcw, 1);
    chk("beq_t_pcsrc", b_ps, 2'b01);
    run_h(7'b1100011, 3'b000, 3'b000, 0, cyc, nreq);
    chk("beq_n_cycles", cyc, 3);
    chk("beq_n_pcw", b_pcw, 0);

    // ---- SW with 1 wait: 5 cycles ----
    run_h(7'b0100011, 3'b010, 3'b000, 1, cyc, nreq);
    chk("sw_cycles", cyc, 5);
    chk("sw_req_cycles", nreq, 2);

    // ---- 2-bit instret wraps after 4 ----
    rst();
    for (int i = 0; i < 4; i++) run_h(7'b0001111, 3'b000, 3'b000, 0, cyc, nreq);
    chk("wrap_4", cnt_h, 0);
    run_h(7'b0001111, 3'b000, 3'b000, 0, cyc, nreq);
    chk("wrap_5", cnt_h, 1);

    // ---- EBREAK -> HALT, reset leaves ----
    op = 7'b1110011; ifh.mem_ready = 1'b1;
    step(); step(); #1;
    chk("halt_state", st_h, 13);
    chk("halt_flag", hlt_h, 1);
    chk("halt_req", ifh.mem_req, 0);
    step(); step(); #1;
    chk("halt_hold", st_h, 13);
    rst(); #1;
    chk("halt_rst_state", st_h, 0);
    chk("halt_rst_instret", cnt_h, 0);
    chk("halt_rst_flag", hlt_h, 0);

    // ---- illegal opcode -> FAULT ----
    run_h(7'b0001111, 3'b000, 3'b000, 0, cyc, nreq);
    op = 7'h7F;
    step(); step(); #1;
    chk("ill_state", st_h, 14);
    chk("ill_fault", flt_h, 1);
    chk("ill_halted", hlt_h, 0);
    step(); step(); step(); #1;
    chk("ill_hold", st_h, 14);
    rst(); #1;
    chk("ill_rst_state", st_h, 0);
    chk("ill_rst_instret", cnt_h, 0);

    // ---- timeout in FETCH: 4 wait cycles, then forced FAULT ----
    ifh.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; chk($sformatf("to_wait%0d", i), st_h, 0); step();
    end
    ifh.mem_ready = 1'b1; #1;  // timeout overrides this ready
    chk("to_last_state", st_h, 0);
    step(); #1;
    chk("to_fault_state", st_h, 14);
    chk("to_fault_flag", flt_h, 1);
    ifh.mem_ready = 1'b0; step(); ifh.mem_ready = 1'b1; step(); #1;
    chk("to_fault_hold", flt_h, 1);
    rst(); #1;
    chk("to_rst_state", st_h, 0);
    chk("to_rst_fault", flt_h, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
